tomasulo_rs_unit: RTL and testbench
===================================

// Module: tomasulo_rs_unit
// PURPOSE
// Reservation station that sits directly downstream of the issue stage.
// - Holds renamed instructions until both source operands are available.
// - Captures operand values broadcast on the common data bus (CDB).
// - Dispatches ready instructions, oldest first, to one functional unit through a registered valid/ready port.
// - Operand tags are ROB indices: 32-row ROB, so TAG_W=5.
// PARAMETERS
// ENTRIES  4   number of station entries (>=2)
// DATA_W   32  operand width
// TAG_W    5   ROB tag width
// OP_W     4   decoded opcode/control width
// PORTS
// clk            in   1           clock, all state updates on rising edge
// rst            in   1           synchronous reset, active-high
// flush          in   1           sync clear of all entries and the output register (mispredict)
// issue_valid    in   1           issue presents an instruction
// issue_ready    out  1           at least one entry free (combinational from busy flags)
// issue_op       in   OP_W        control field
// issue_tag      in   TAG_W       destination ROB tag
// issue_vj/vk    in   DATA_W      operand values, used when qj/qk_pend=0
// issue_qj/qk    in   TAG_W       producer tags, used when *_pend=1
// issue_qj_pend  in   1           operand j is still waiting on a tag
// issue_qk_pend  in   1           operand k is still waiting on a tag
// cdb_valid      in   1           CDB broadcast this cycle
// cdb_tag        in   TAG_W       broadcasting ROB tag
// cdb_data       in   DATA_W      broadcast value
// disp_valid     out  1           registered: dispatch bundle valid
// disp_ready     in   1           functional unit accepts the bundle
// disp_op        out  OP_W        registered dispatch fields
// disp_tag       out  TAG_W       registered dispatch fields
// disp_vj/vk     out  DATA_W      registered dispatch fields
// count          out  $clog2(ENTRIES+1)  busy entries, excluding the output register
// BEHAVIOUR
// - Reset or flush: all busy=0, disp_valid=0, disp_* = 0, count=0, age matrix cleared. Reset/flush beats every other event in that cycle.
// - Issue fires when issue_valid && issue_ready.
//   - Writes the lowest-index free entry and marks it youngest.
//   - issue_ready sees busy flags at the start of the cycle; an entry freed by dispatch that same cycle is not reusable until the next cycle.
//   - issue_valid while !issue_ready is ignored; no state changes.
// - CDB wakeup: every busy entry with a pending operand whose tag == cdb_tag and cdb_valid captures cdb_data and clears that pending bit.
//   - Both j and k may wake in the same cycle.
// - Same-cycle bypass: an issuing operand with *_pend=1 and tag == cdb_tag while cdb_valid is written already resolved with cdb_data.
// - Ready: entry busy and both pend bits clear at the start of the cycle. Wakeup makes an entry eligible from the next cycle.
// - Age: an ENTRIESxENTRIES age matrix. The select picks the oldest ready entry; no ties are possible.
// - Output register loads when (!disp_valid || disp_ready) and a ready entry exists.
//   - Copies op/tag/vj/vk, frees the entry, count decrements.
//   - Otherwise, if disp_ready, disp_valid drops to 0.
// - Stall: disp_valid=1 && !disp_ready holds all disp_* stable, with no entry freed. Wakeups and issues continue.
// - Latency: an instruction issued ready at edge E gives disp_valid=1 after edge E+1. A CDB wake at edge W gives dispatch after edge W+1.
// - count is updated each cycle as +issue -dispatch_load. Simultaneous issue and load keeps count unchanged.
// - No CDB match against free entries; tags in free entries are don't-care.
// TESTING
// - rst=1 for 2 cycles -> issue_ready=1, disp_valid=0, count=0, disp_* = 0.
// - Issue op=3 tag=9 vj=5 vk=7 both ready, disp_ready=1 -> after 2nd edge: disp_valid=1, op=3, tag=9, vj=5, vk=7; next cycle disp_valid=0, count=0.
// - Issue tag=2 with qj=4 pending, vk=1; 3 cycles later cdb tag=4 data=0x1234 -> disp_valid one edge after wake, disp_vj=0x1234, disp_vk=1.
// - Issue with qk=6 pending while cdb_valid, tag=6, data=0xAA -> entry ready at once; dispatch after 2nd edge with vk=0xAA.
// - Fill 4 entries all pending -> issue_ready=0, count=4; extra issue_valid ignored. Wake entries in order 3,1 -> dispatch order 3 then 1 (oldest ready). With disp_ready=0 the output is held stable for 5 cycles.
// - Entries busy plus disp_valid=1, assert flush together with issue_valid and a cdb match -> next cycle count=0, disp_valid=0, issue_ready=1; no ghost dispatch afterwards.

Source files
------------

// File: rtl/tomasulo_rs_unit.sv
// Reservation station: holds renamed instructions until both operands arrive
// via issue or CDB, then dispatches the oldest ready one through a registered port.
module tomasulo_rs_unit #(
  parameter int ENTRIES = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 5,
  parameter int OP_W    = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic                             issue_valid_i,
  output logic                             issue_ready_o,
  input  logic [OP_W-1:0]                  issue_op_i,
  input  logic [TAG_W-1:0]                 issue_tag_i,
  input  logic [DATA_W-1:0]                issue_vj_i,
  input  logic [DATA_W-1:0]                issue_vk_i,
  input  logic [TAG_W-1:0]                 issue_qj_i,
  input  logic [TAG_W-1:0]                 issue_qk_i,
  input  logic                             issue_qj_pend_i,
  input  logic                             issue_qk_pend_i,
  input  logic                             cdb_valid_i,
  input  logic [TAG_W-1:0]                 cdb_tag_i,
  input  logic [DATA_W-1:0]                cdb_data_i,
  output logic                             disp_valid_o,
  input  logic                             disp_ready_i,
  output logic [OP_W-1:0]                  disp_op_o,
  output logic [TAG_W-1:0]                 disp_tag_o,
  output logic [DATA_W-1:0]                disp_vj_o,
  output logic [DATA_W-1:0]                disp_vk_o,
  output logic [$clog2(ENTRIES+1)-1:0]     count_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES+1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; a valid source keeps its payload stable until that edge.

  logic [ENTRIES-1:0] busy_q, busy_d;
  logic [ENTRIES-1:0] pj_q, pj_d;
  logic [ENTRIES-1:0] pk_q, pk_d;
  logic [TAG_W-1:0]   qj_q  [ENTRIES];
  logic [TAG_W-1:0]   qj_d  [ENTRIES];
  logic [TAG_W-1:0]   qk_q  [ENTRIES];
  logic [TAG_W-1:0]   qk_d  [ENTRIES];
  logic [DATA_W-1:0]  vj_q  [ENTRIES];
  logic [DATA_W-1:0]  vj_d  [ENTRIES];
  logic [DATA_W-1:0]  vk_q  [ENTRIES];
  logic [DATA_W-1:0]  vk_d  [ENTRIES];
  logic [OP_W-1:0]    op_q  [ENTRIES];
  logic [OP_W-1:0]    op_d  [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  // age_q[i][j] = 1 means entry i was issued before entry j.
  logic [ENTRIES-1:0] age_q [ENTRIES];
  logic [ENTRIES-1:0] age_d [ENTRIES];

  logic               disp_valid_q, disp_valid_d;
  logic [OP_W-1:0]    disp_op_q, disp_op_d;
  logic [TAG_W-1:0]   disp_tag_q, disp_tag_d;
  logic [DATA_W-1:0]  disp_vj_q, disp_vj_d;
  logic [DATA_W-1:0]  disp_vk_q, disp_vk_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               issue_fire;
  logic [IDX_W-1:0]   free_idx;
  logic [ENTRIES-1:0] ready;
  logic               any_ready;
  logic               is_oldest;
  logic [IDX_W-1:0]   sel_idx;
  logic               load;
  logic               new_pj, new_pk;
  logic [DATA_W-1:0]  new_vj, new_vk;

  assign issue_ready_o = ~&busy_q;
  assign issue_fire    = issue_valid_i && issue_ready_o;
  assign ready         = busy_q & ~pj_q & ~pk_q;
  assign any_ready     = |ready;
  assign load          = (!disp_valid_q || disp_ready_i) && any_ready;

  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  // Exactly one ready entry is older than every other ready entry.
  always_comb begin
    sel_idx   = '0;
    is_oldest = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      is_oldest = ready[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (j != i && ready[j] && !age_q[i][j]) is_oldest = 1'b0;
      end
      if (is_oldest) sel_idx = IDX_W'(i);
    end
  end

  // Same-cycle bypass for operands whose producer is on the CDB right now.
  always_comb begin
    new_pj = issue_qj_pend_i;
    new_vj = issue_vj_i;
    new_pk = issue_qk_pend_i;
    new_vk = issue_vk_i;
    if (issue_qj_pend_i && cdb_valid_i && issue_qj_i == cdb_tag_i) begin
      new_pj = 1'b0;
      new_vj = cdb_data_i;
    end
    if (issue_qk_pend_i && cdb_valid_i && issue_qk_i == cdb_tag_i) begin
      new_pk = 1'b0;
      new_vk = cdb_data_i;
    end
  end

  always_comb begin
    busy_d       = busy_q;
    pj_d         = pj_q;
    pk_d         = pk_q;
    qj_d         = qj_q;
    qk_d         = qk_q;
    vj_d         = vj_q;
    vk_d         = vk_q;
    op_d         = op_q;
    tag_d        = tag_q;
    age_d        = age_q;
    disp_valid_d = disp_valid_q;
    disp_op_d    = disp_op_q;
    disp_tag_d   = disp_tag_q;
    disp_vj_d    = disp_vj_q;
    disp_vk_d    = disp_vk_q;
    count_d      = count_q + CNT_W'(issue_fire) - CNT_W'(load);

    for (int i = 0; i < ENTRIES; i++) begin
      if (busy_q[i] && pj_q[i] && cdb_valid_i && qj_q[i] == cdb_tag_i) begin
        pj_d[i] = 1'b0;
        vj_d[i] = cdb_data_i;
      end
      if (busy_q[i] && pk_q[i] && cdb_valid_i && qk_q[i] == cdb_tag_i) begin
        pk_d[i] = 1'b0;
        vk_d[i] = cdb_data_i;
      end
    end

    if (load) begin
      busy_d[sel_idx] = 1'b0;
      disp_valid_d    = 1'b1;
      disp_op_d       = op_q[sel_idx];
      disp_tag_d      = tag_q[sel_idx];
      disp_vj_d       = vj_q[sel_idx];
      disp_vk_d       = vk_q[sel_idx];
    end else if (disp_ready_i) begin
      disp_valid_d = 1'b0;
    end

    // The issued entry becomes younger than everything else.
    if (issue_fire) begin
      busy_d[free_idx] = 1'b1;
      pj_d[free_idx]   = new_pj;
      pk_d[free_idx]   = new_pk;
      qj_d[free_idx]   = issue_qj_i;
      qk_d[free_idx]   = issue_qk_i;
      vj_d[free_idx]   = new_vj;
      vk_d[free_idx]   = new_vk;
      op_d[free_idx]   = issue_op_i;
      tag_d[free_idx]  = issue_tag_i;
      for (int i = 0; i < ENTRIES; i++) age_d[i][free_idx] = 1'b1;
      age_d[free_idx] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      busy_q       <= '0;
      pj_q         <= '0;
      pk_q         <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
        op_q[i]  <= '0;
        tag_q[i] <= '0;
        age_q[i] <= '0;
      end
      disp_valid_q <= 1'b0;
      disp_op_q    <= '0;
      disp_tag_q   <= '0;
      disp_vj_q    <= '0;
      disp_vk_q    <= '0;
      count_q      <= '0;
    end else begin
      busy_q       <= busy_d;
      pj_q         <= pj_d;
      pk_q         <= pk_d;
      qj_q         <= qj_d;
      qk_q         <= qk_d;
      vj_q         <= vj_d;
      vk_q         <= vk_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      age_q        <= age_d;
      disp_valid_q <= disp_valid_d;
      disp_op_q    <= disp_op_d;
      disp_tag_q   <= disp_tag_d;
      disp_vj_q    <= disp_vj_d;
      disp_vk_q    <= disp_vk_d;
      count_q      <= count_d;
    end
  end

  assign disp_valid_o = disp_valid_q;
  assign disp_op_o    = disp_op_q;
  assign disp_tag_o   = disp_tag_q;
  assign disp_vj_o    = disp_vj_q;
  assign disp_vk_o    = disp_vk_q;
  assign count_o      = count_q;

endmodule

// File: tb/tb_tomasulo_rs_unit.sv
// Directed bench for tomasulo_rs_unit: issue, CDB wakeup, bypass, age order,
// stall hold and flush, each step checked against hand-computed values.
module tb_tomasulo_rs_unit;

  localparam int ENTRIES = 4;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 5;
  localparam int OP_W    = 4;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic              issue_valid, issue_ready;
  logic [OP_W-1:0]   issue_op;
  logic [TAG_W-1:0]  issue_tag, issue_qj, issue_qk;
  logic [DATA_W-1:0] issue_vj, issue_vk;
  logic              issue_qj_pend, issue_qk_pend;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              disp_valid, disp_ready;
  logic [OP_W-1:0]   disp_op;
  logic [TAG_W-1:0]  disp_tag;
  logic [DATA_W-1:0] disp_vj, disp_vk;
  logic [2:0]        count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tomasulo_rs_unit #(
    .ENTRIES(ENTRIES), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_op_i(issue_op), .issue_tag_i(issue_tag),
    .issue_vj_i(issue_vj), .issue_vk_i(issue_vk),
    .issue_qj_i(issue_qj), .issue_qk_i(issue_qk),
    .issue_qj_pend_i(issue_qj_pend), .issue_qk_pend_i(issue_qk_pend),
    .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
    .disp_valid_o(disp_valid), .disp_ready_i(disp_ready),
    .disp_op_o(disp_op), .disp_tag_o(disp_tag),
    .disp_vj_o(disp_vj), .disp_vk_o(disp_vk),
    .count_o(count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] tag,
                       input logic [31:0] vj, input logic [31:0] vk,
                       input logic jp, input logic [4:0] qj,
                       input logic kp, input logic [4:0] qk);
    issue_valid   = 1'b1;
    issue_op      = op;
    issue_tag     = tag;
    issue_vj      = vj;
    issue_vk      = vk;
    issue_qj_pend = jp;
    issue_qj      = qj;
    issue_qk_pend = kp;
    issue_qk      = qk;
  endtask

  task automatic cdb(input logic v, input logic [4:0] tag, input logic [31:0] data);
    cdb_valid = v;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  task automatic check_disp(input string name, input logic [4:0] tag,
                            input logic [31:0] vj, input logic [31:0] vk);
    check({name, "_valid"}, disp_valid, 1);
    check({name, "_tag"}, disp_tag, tag);
    check({name, "_vj"}, disp_vj, vj);
    check({name, "_vk"}, disp_vk, vk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; disp_ready = 1'b1;
    issue_valid = 1'b0;
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    issue_valid = 1'b0;
    cdb(0, 0, 0);

    // Reset
    tick(); tick();
    rst = 1'b0;
    check("rst_issue_ready", issue_ready, 1);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_count", count, 0);
    check("rst_disp_fields", {disp_op, disp_tag, disp_vj, disp_vk}, 0);

    // Ready-on-issue: dispatch after the second edge
    issue(3, 9, 5, 7, 0, 0, 0, 0);
    tick();
    issue_valid = 1'b0;
    check("t1_count_after_issue", count, 1);
    check("t1_not_yet_valid", disp_valid, 0);
    tick();
    check_disp("t1_disp", 9, 5, 7);
    check("t1_op", disp_op, 3);
    check("t1_count_after_load", count, 0);
    tick();
    check("t1_valid_drop", disp_valid, 0);
    check("t1_count_end", count, 0);

    // Operand j waits on tag 4
    issue(1, 2, 0, 1, 1, 4, 0, 0);
    tick();
    issue_valid = 1'b0;
    tick(); tick();
    check("t2_waiting", disp_valid, 0);
    check("t2_count", count, 1);
    cdb(1, 4, 32'h1234);
    tick();
    cdb(0, 0, 0);
    check("t2_wake_edge", disp_valid, 0);
    tick();
    check_disp("t2_disp", 2, 32'h1234, 1);
    tick();
    check("t2_valid_drop", disp_valid, 0);

    // Bypass: operand k's producer broadcasts in the issue cycle
    issue(2, 5, 3, 0, 0, 0, 1, 6);
    cdb(1, 6, 32'hAA);
    tick();
    issue_valid = 1'b0;
    cdb(0, 0, 0);
    check("t3_count", count, 1);
    check("t3_not_yet_valid", disp_valid, 0);
    tick();
    check_disp("t3_disp", 5, 3, 32'hAA);
    tick();
    check("t3_valid_drop", disp_valid, 0);

    // Fill all four entries with pending j operands (tags 20..23)
    disp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(4'(i), 5'(10 + i), 0, 32'(100 + i), 1, 5'(20 + i), 0, 0);
      tick();
    end
    issue_valid = 1'b0;
    check("t4_full_ready", issue_ready, 0);
    check("t4_full_count", count, 4);
    issue(7, 14, 1, 1, 0, 0, 0, 0);
    tick();
    issue_valid = 1'b0;
    check("t4_ignored_count", count, 4);
    check("t4_ignored_valid", disp_valid, 0);

    // Wake entry 3 first; it dispatches alone
    cdb(1, 23, 32'h33);
    tick();
    cdb(0, 0, 0);
    check("t4_wake3_edge", disp_valid, 0);
    tick();
    check_disp("t4_disp3", 13, 32'h33, 103);
    check("t4_count3", count, 3);

    // Stall for 5 cycles while entries 1 then 2 wake
    for (int c = 0; c < 5; c++) begin
      if (c == 0) cdb(1, 21, 32'h11);
      else if (c == 1) cdb(1, 22, 32'h22);
      else cdb(0, 0, 0);
      tick();
      check_disp("t4_hold", 13, 32'h33, 103);
      check("t4_hold_op", disp_op, 3);
      check("t4_hold_count", count, 3);
    end

    // Both 1 and 2 ready: the older (entry 1) goes first
    disp_ready = 1'b1;
    tick();
    check_disp("t4_disp1", 11, 32'h11, 101);
    check("t4_count1", count, 2);
    tick();
    check_disp("t4_disp2", 12, 32'h22, 102);
    check("t4_count2", count, 1);

    // Flush beats issue, wakeup and the held output
    disp_ready = 1'b0;
    flush = 1'b1;
    issue(5, 15, 9, 9, 0, 0, 0, 0);
    cdb(1, 20, 32'h77);
    tick();
    flush = 1'b0;
    issue_valid = 1'b0;
    cdb(0, 0, 0);
    check("t5_count", count, 0);
    check("t5_disp_valid", disp_valid, 0);
    check("t5_issue_ready", issue_ready, 1);
    check("t5_disp_fields", {disp_op, disp_tag, disp_vj, disp_vk}, 0);
    disp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t5_no_ghost", disp_valid, 0);
      check("t5_no_ghost_count", count, 0);
    end

    // Both operands wake on the same broadcast
    issue(6, 17, 0, 0, 1, 7, 1, 7);
    tick();
    issue_valid = 1'b0;
    cdb(1, 7, 32'h55);
    tick();
    cdb(0, 0, 0);
    check("t6_wake_edge", disp_valid, 0);
    tick();
    check_disp("t6_disp", 17, 32'h55, 32'h55);
    check("t6_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
